// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state type and width constants for the skid register
package pipe_pkg;

  // Default payload width in bits.
  localparam int PIPE_W = 32;

  // Default stall-counter width in bits.
  localparam int PIPE_CNT_W = 16;

  // Occupancy of the two-entry buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - valid/ready handshake bundle for the skid register
interface pipe_skid_reg_if
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Dout;

  // Upstream producer and downstream consumer seen from outside the block.
  modport master (
    output in_valid, Din, out_ready,
    input  in_ready, out_valid, Dout
  );

  // The skid register itself.
  modport slave (
    input  in_valid, Din, out_ready,
    output in_ready, out_valid, Dout
  );

endinterface

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register; optional stall counter under PIPE_STALL_CNT_EN
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W,
  parameter int CNT_W = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  pipe_skid_reg_if.slave   bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  // Reject illegal configurations at elaboration.
  if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_param_check
    $error("pipe_skid_reg: WIDTH must be 1..64 and CNT_W at least 1");
  end

  pipe_state_e      state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;

  // Handshake outputs depend only on registered state, so out_ready never
  // reaches in_ready combinationally.
  assign bus.in_ready  = (state != SKID);
  assign bus.out_valid = (state != EMPTY);
  assign bus.Dout      = main_q;

  // Occupancy FSM: main holds the head item, skid catches the one extra
  // item accepted while the consumer stalls.
  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (bus.in_valid) begin
            main_q <= bus.Din;
            state  <= FULL;
          end
        end
        FULL: begin
          if (bus.in_valid && bus.out_ready) begin
            main_q <= bus.Din;
          end else if (bus.in_valid) begin
            skid_q <= bus.Din;
            state  <= SKID;
          end else if (bus.out_ready) begin
            state  <= EMPTY;
          end
        end
        SKID: begin
          if (bus.out_ready) begin
            main_q <= skid_q;
            state  <= FULL;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  assign stall_cnt = stall_q;

  // Count cycles the consumer leaves a valid item waiting; saturates, and
  // survives flush so stalls can be measured across pipeline restarts.
  always_ff @(posedge clk) begin
    if (clr) begin
      stall_q <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench: vector table, corner sequences, random vs queue model
module tb_pipe_skid_reg;

  localparam int W  = 32;
  localparam int CW = 4;

  logic clk;
  logic clr;
  logic flush;

  pipe_skid_reg_if #(.WIDTH(W)) bus ();

`ifdef PIPE_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  pipe_skid_reg #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .flush    (flush),
    .bus      (bus)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO of held items, capacity two.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_dout = '0;
  int           m_cnt  = 0;

  typedef struct {
    logic         c;
    logic         f;
    logic         iv;
    logic [W-1:0] din;
    logic         ordy;
    logic         e_ov;
    logic         e_ir;
    logic [W-1:0] e_dout;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic c, input logic f, input logic iv,
                              input logic [W-1:0] din, input logic ordy,
                              input logic e_ov, input logic e_ir,
                              input logic [W-1:0] e_dout);
    vec_t v;
    v.c = c; v.f = f; v.iv = iv; v.din = din; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_dout = e_dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model, and settle after the edge.
  task automatic apply(input logic c, input logic f, input logic iv,
                       input logic [W-1:0] din, input logic ordy);
    bit pop;
    bit push;
    clr           = c;
    flush         = f;
    bus.in_valid  = iv;
    bus.Din       = din;
    bus.out_ready = ordy;
    if (c) begin
      mq.delete();
      m_dout = '0;
      m_cnt  = 0;
    end else begin
      if (mq.size() > 0 && !ordy && m_cnt < (1 << CW) - 1) m_cnt++;
      if (f) begin
        mq.delete();
        m_dout = '0;
      end else begin
        pop  = (mq.size() > 0) && ordy;
        push = iv && (mq.size() < 2);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(din);
        if (mq.size() > 0) m_dout = mq[0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.Din       = '0;
    bus.out_ready = 1'b0;

    //            clr  fl   iv   din    ordy  ov   ir   dout
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 32'h1, 1'b1, 1'b1, 1'b1, 32'h1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b1, 32'h2, 1'b1, 1'b1, 1'b1, 32'h2);
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 32'h3);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h3);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 32'hA);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1, 32'hE, 1'b0, 1'b1, 1'b0, 32'hA);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hB);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b1, 32'hA);
    tbl[12] = mk(1'b0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 32'hA);
    tbl[13] = mk(1'b0, 1'b1, 1'b1, 32'hC, 1'b0, 1'b0, 1'b1, 32'h0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    tbl[15] = mk(1'b0, 1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h5);
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 32'h6, 1'b0, 1'b1, 1'b0, 32'h5);
    tbl[17] = mk(1'b1, 1'b1, 1'b1, 32'h7, 1'b1, 1'b0, 1'b1, 32'h0);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i].c, tbl[i].f, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("vec%0d Dout", i), 64'(bus.Dout), 64'(tbl[i].e_dout));
`ifdef PIPE_STALL_CNT_EN
      if (i == 1 || i == 17) chk($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'd0);
`endif
    end

`ifdef PIPE_STALL_CNT_EN
    // Saturation, flush-persistence and clear of the stall counter.
    apply(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("stall reset", 64'(stall_cnt), 64'd0);
    apply(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    for (int k = 0; k < 20; k++) apply(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("stall saturate", 64'(stall_cnt), 64'd15);
    chk("stall hold Dout", 64'(bus.Dout), 64'h55);
    apply(1'b0, 1'b1, 1'b0, '0, 1'b0);
    chk("stall after flush", 64'(stall_cnt), 64'd15);
    chk("flush out_valid", 64'(bus.out_valid), 64'd0);
    apply(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("stall after clr", 64'(stall_cnt), 64'd0);
`endif

    // Randomized traffic against the queue model.
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(99) == 0), ($urandom_range(39) == 0),
            ($urandom_range(3) != 0), W'($urandom), ($urandom_range(1) == 1));
      chk("rnd out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
      chk("rnd in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
      chk("rnd Dout", 64'(bus.Dout), 64'(m_dout));
`ifdef PIPE_STALL_CNT_EN
      chk("rnd stall_cnt", 64'(stall_cnt), 64'(m_cnt));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
